instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
- Reader side of the instruction memory; the IF stage of the 5-stage MIPS pipeline.
- Owns the PC and drives the byte address to the combinational instruction memory, which returns 32-bit big-endian words.
- Registers each fetched word and its PC+4 into the IF/ID pipeline register.
- Accepts stall, flush, redirect (branch/jump) and halt control from the hazard unit and EX/ID stages.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded at reset.
- ADDR_W, 32: PC and address width.
- INST_BYTES, 4: bytes per instruction; the PC increment.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  fetch byte address; combinationally equal to pc.
- imem_inst  in  32  instruction word returned by memory in the same cycle.
- stall  in  1  hazard stall; hold PC and IF/ID.
- flush  in  1  squash IF/ID contents (insert bubble).
- redirect_valid  in  1  load PC from redirect_target.
- redirect_target  in  ADDR_W  branch/jump target byte address.
- halt_req  in  1  stop fetching after the current cycle.
- resume  in  1  leave the HALTED state.
- pc  out  ADDR_W  current fetch PC.
- ifid_inst  out  32  IF/ID instruction.
- ifid_pc_plus4  out  ADDR_W  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, ifid_inst=NOP (32'h0), ifid_pc_plus4=0, ifid_valid=0, state=BOOT. Releasing reset mid-operation discards all in-flight state.
- FSM states: BOOT, RUN, HALTED.
  - BOOT: exactly one cycle after reset release; no fetch is captured, ifid_valid=0, pc unchanged. Moves to RUN.
  - RUN: normal fetch. halt_req=1 moves to HALTED at the next edge. The instruction fetched in that cycle is still captured, subject to stall and flush.
  - HALTED: pc frozen, IF/ID loads NOP with ifid_valid=0 every cycle. resume=1 returns to RUN at the next edge. A redirect_valid received while HALTED still updates pc.
- Fetch latency: zero. imem_addr=pc, and imem_inst is sampled at the same clk edge into IF/ID, so an instruction appears on IF/ID one cycle after its PC is presented.
- PC update priority, highest first:
  1. redirect_valid: pc <= {redirect_target[31:2],2'b00}.
  2. stall or HALTED: pc holds.
  3. otherwise: pc <= pc+INST_BYTES.
- Redirect therefore overrides stall.
- IF/ID update priority, highest first:
  1. flush or HALTED or BOOT: NOP, valid=0.
  2. stall: hold.
  3. otherwise: load imem_inst, pc+4, valid=1.
- A redirect without flush still captures the wrong-path word. The control unit must assert flush together with a taken branch or jump.
- Arithmetic: pc+4 is unsigned modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0. Memory aliasing above 1 KiB belongs to the memory, not to this block.
- Simultaneous halt_req and resume in RUN: halt wins. In HALTED: resume wins.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- When defined, the block adds outputs fetch_count[31:0] and bubble_count[31:0]. Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - fetch_count increments on every edge where IF/ID loads with valid=1.
  - bubble_count increments on every edge where IF/ID loads a NOP due to flush, BOOT or HALTED.
  - Stall-hold cycles count in neither counter.
- When undefined, the ports and logic do not exist and behaviour is otherwise identical.

Decomposition:
- Package ifetch_pkg holds:
  - typedef enum logic [1:0] {BOOT, RUN, HALTED} ifetch_state_t
  - localparam NOP_INST=32'h0000_0000
  - localparam INST_BYTES=4
  - typedef struct ifid_t {inst, pc_plus4, valid}
- One sub-module, ifid_pipe_reg: an async-reset register of ifid_t with hold (stall) and bubble (flush) controls. It is reused by later pipeline registers.

Test Plan:
- Reset with rst_n=0 mid-cycle -> pc=0 and ifid_valid=0 immediately. After release: one BOOT cycle with ifid_valid=0, then pc steps 0,4,8,…
- Memory word 0x00433820 at byte 20, no stall -> the cycle after pc=20, ifid_inst=0x00433820, ifid_pc_plus4=24, ifid_valid=1.
- stall=1 for 2 cycles at pc=24 -> pc stays 24 and IF/ID holds its word. On release pc=28.
- J at pc=80: redirect_valid=1, target=88, flush=1 -> next pc=88, IF/ID=NOP with valid=0. The word at 84 is never valid.
- redirect_valid=1 with stall=1, target=0x67 -> pc=0x64 (redirect beats stall, low bits cleared).
- halt_req in RUN at pc=40 -> HALTED, pc frozen at 44, ifid_valid=0. resume -> RUN and the fetch at 44 proceeds. With IFETCH_PERF_CNT_EN, bubble_count increments once per halted cycle.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the IF stage and the pipeline registers built on ifid_t.
package ifetch_pkg;

  localparam int          IFID_ADDR_W = 32;
  localparam logic [31:0] NOP_INST    = 32'h0000_0000;
  localparam int          INST_BYTES  = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } ifetch_state_t;

  typedef struct packed {
    logic [31:0]            inst;
    logic [IFID_ADDR_W-1:0] pc_plus4;
    logic                   valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{inst: NOP_INST, pc_plus4: '0, valid: 1'b0};

endpackage

// File: rtl/ifid_pipe_reg.sv
// Pipeline register of ifid_t with hold (stall) and bubble (flush) controls; bubble beats hold.
module ifid_pipe_reg
  import ifetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold_i,
  input  logic  bubble_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (bubble_i) begin
      data_d = IFID_BUBBLE;
    end else if (!hold_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= IFID_BUBBLE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC, BOOT/RUN/HALTED control and the IF/ID register.
// Optional fetch/bubble performance counters are enabled with IFETCH_PERF_CNT_EN.
module instruction_fetch_stage #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                INST_BYTES = ifetch_pkg::INST_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ifid_inst,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  output logic              ifid_valid
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       bubble_count
`endif
);

  import ifetch_pkg::*;

  ifetch_state_t     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              ifid_bubble;
  ifid_t             ifid_d, ifid_q;

  assign pc_inc = pc_q + ADDR_W'(INST_BYTES);

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_req) state_d = HALTED;
      HALTED:  if (resume)   state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Redirect wins over stall and over the frozen PC of BOOT/HALTED.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
    end else if (!stall && state_q == RUN) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign ifid_bubble = flush || (state_q != RUN);
  assign ifid_d      = '{inst: imem_inst, pc_plus4: IFID_ADDR_W'(pc_inc), valid: 1'b1};

  ifid_pipe_reg u_ifid (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold_i   (stall),
    .bubble_i (ifid_bubble),
    .d_i      (ifid_d),
    .q_o      (ifid_q)
  );

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign ifid_inst     = ifid_q.inst;
  assign ifid_pc_plus4 = ADDR_W'(ifid_q.pc_plus4);
  assign ifid_valid    = ifid_q.valid;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Stall-hold edges fall in neither bucket; both counters saturate.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ifid_bubble) begin
      if (bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (!stall) begin
      if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule
